// File: rtl/bcd_cascade_counter.sv
// bcd_cascade_counter
// Extends the upstream mod-10 units counter into DIGITS higher BCD decades.
// Each units wrap tick advances the decade count by one. The block adds an
// optional saturate-at-all-nines mode, an edge-type compare pulse against a
// programmable BCD value, and a valid/ready snapshot port that captures
// {count, units} atomically for the register-read side.
module bcd_cascade_counter #(
  parameter int DIGITS = 3,
  parameter bit SAT    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tick_in,
  input  logic [3:0]            units_bcd,
  input  logic                  clr,
  input  logic                  hold,
  input  logic [4*DIGITS-1:0]   cmp_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  cmp_hit,
  input  logic                  snap_req,
  output logic                  snap_valid,
  input  logic                  snap_ready,
  output logic [4*DIGITS+3:0]   snap_data
);

  localparam int CW = 4 * DIGITS;

  typedef enum logic {
    IDLE    = 1'b0,
    HOLDING = 1'b1
  } snap_state_t;

  // Single BCD digit increment. Anything at or above 9 folds back to 0 so a
  // digit can never escape the 0..9 range.
  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Ripple a +1 through the decades digit by digit. A digit only moves when
  // every lower digit was 9; there is no binary adder spanning digits.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        r[4*i +: 4] = digit_inc(v[4*i +: 4]);
        carry       = (v[4*i +: 4] == 4'd9);
      end
    end
    return r;
  endfunction

  // True when every decade reads 9, i.e. the next tick overflows.
  function automatic logic all_nines(input logic [CW-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      r = r & (v[4*i +: 4] == 4'd9);
    end
    return r;
  endfunction

  // True when every nibble is a legal BCD digit. An illegal compare value
  // must never produce a hit.
  function automatic logic bcd_valid(input logic [CW-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      r = r & (v[4*i +: 4] <= 4'd9);
    end
    return r;
  endfunction

  // ---- stage p0: qualify the tick and form the next count ----
  logic          count_tick_p0;
  logic          at_max_p0;
  logic [CW-1:0] cnt_next_p0;
  logic          ovf_next_p0;
  logic          upd_next_p0;
  logic          sat_next_p0;

  logic          sat_flag;
  logic          tick_upd_p1;

  assign count_tick_p0 = tick_in & ~hold & ~clr;
  assign at_max_p0     = all_nines(bcd_out);

  // Next-count selection: clr dominates, then a qualified tick either
  // increments/wraps or, in saturate mode, sticks at all-nines.
  always_comb begin
    cnt_next_p0 = bcd_out;
    ovf_next_p0 = 1'b0;
    upd_next_p0 = 1'b0;
    sat_next_p0 = sat_flag;
    if (clr) begin
      cnt_next_p0 = '0;
      sat_next_p0 = 1'b0;
    end else if (count_tick_p0) begin
      if (at_max_p0 && SAT) begin
        // Only the first saturating tick reports overflow.
        ovf_next_p0 = ~sat_flag;
        sat_next_p0 = 1'b1;
      end else begin
        cnt_next_p0 = bcd_inc(bcd_out);
        ovf_next_p0 = at_max_p0;
        upd_next_p0 = 1'b1;
      end
    end
  end

  // ---- stage p1: registered count, overflow pulse, saturation state ----
  // Count register plus the flags that travel with each count update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcd_out     <= '0;
      ovf         <= 1'b0;
      sat_flag    <= 1'b0;
      tick_upd_p1 <= 1'b0;
    end else begin
      bcd_out     <= cnt_next_p0;
      ovf         <= ovf_next_p0;
      sat_flag    <= sat_next_p0;
      tick_upd_p1 <= upd_next_p0;
    end
  end

  // ---- stage p2: compare pulse ----
  // Fires only in the cycle after a tick moved the count onto cmp_val, so a
  // count that merely stays equal (hold, saturation, clr to 0) is silent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_hit <= 1'b0;
    end else begin
      cmp_hit <= tick_upd_p1 & bcd_valid(cmp_val) & (bcd_out == cmp_val);
    end
  end

  // ---- snapshot handshake ----
  snap_state_t state;
  snap_state_t state_next;
  logic        capture;

  // Snapshot FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Snapshot FSM transitions: requests are only honoured in IDLE and
  // ready is only meaningful while a snapshot is being offered.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (snap_req) begin
          capture    = 1'b1;
          state_next = HOLDING;
        end
      end
      HOLDING: begin
        if (snap_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign snap_valid = (state == HOLDING);

  // Snapshot register: count and units captured in the same edge so the
  // pair is always coherent; untouched until the next accepted request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_data <= '0;
    end else if (capture) begin
      snap_data <= {bcd_out, units_bcd};
    end
  end

  // Every decade of the count stays a legal BCD digit.
  a_digits_legal: assert property (@(posedge clk) disable iff (!rstn)
    bcd_valid(bcd_out));

  // An offered snapshot does not change until it is taken.
  a_snap_stable: assert property (@(posedge clk) disable iff (!rstn)
    (snap_valid && !snap_ready) |=> $stable(snap_data));

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// tb_bcd_cascade_counter
// Drives a SAT=0 and a SAT=1 instance with identical stimulus and checks both
// every cycle against an integer-valued reference model, plus a directed
// vector table and hand-written corner sequences.
module tb_bcd_cascade_counter;

  localparam int DIGITS = 3;
  localparam int CW     = 4 * DIGITS;
  localparam int MAXV   = 999;

  logic          clk;
  logic          rstn;
  logic          tick_in;
  logic [3:0]    units_bcd;
  logic          clr;
  logic          hold;
  logic [CW-1:0] cmp_val;
  logic          snap_req;
  logic          snap_ready;

  logic [CW-1:0]   bcd_o  [2];
  logic            ovf_o  [2];
  logic            hit_o  [2];
  logic            sv_o   [2];
  logic [CW+3:0]   snap_o [2];

  int checks = 0;
  int errors = 0;
  int ovf_cnt [2];
  int hit_cnt [2];

  // reference model state (count kept as a plain integer)
  int          m_cnt  [2];
  bit          m_sat  [2];
  bit          m_ovf  [2];
  bit          m_hit  [2];
  bit          m_upd  [2];
  bit          m_hold [2];
  logic [15:0] m_snap [2];

  bcd_cascade_counter #(.DIGITS(DIGITS), .SAT(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .tick_in(tick_in), .units_bcd(units_bcd),
    .clr(clr), .hold(hold), .cmp_val(cmp_val), .bcd_out(bcd_o[0]),
    .ovf(ovf_o[0]), .cmp_hit(hit_o[0]), .snap_req(snap_req),
    .snap_valid(sv_o[0]), .snap_ready(snap_ready), .snap_data(snap_o[0])
  );

  bcd_cascade_counter #(.DIGITS(DIGITS), .SAT(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .tick_in(tick_in), .units_bcd(units_bcd),
    .clr(clr), .hold(hold), .cmp_val(cmp_val), .bcd_out(bcd_o[1]),
    .ovf(ovf_o[1]), .cmp_hit(hit_o[1]), .snap_req(snap_req),
    .snap_valid(sv_o[1]), .snap_ready(snap_ready), .snap_data(snap_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] int2bcd(input int n);
    logic [CW-1:0] r;
    r[3:0]  = 4'(n % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[11:8] = 4'((n / 100) % 10);
    return r;
  endfunction

  function automatic int bcd2int(input logic [CW-1:0] v);
    int acc;
    int d;
    acc = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) return -1;
      acc = acc * 10 + d;
    end
    return acc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_sat[k] = 0; m_ovf[k] = 0; m_hit[k] = 0;
      m_upd[k] = 0; m_hold[k] = 0; m_snap[k] = '0;
    end
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_step();
    int  cmp_int;
    bit  tk;
    cmp_int = bcd2int(cmp_val);
    tk = tick_in && !hold && !clr;
    for (int k = 0; k < 2; k++) begin
      m_hit[k] = m_upd[k] && (m_cnt[k] == cmp_int);
      if (!m_hold[k]) begin
        if (snap_req) begin
          m_snap[k] = {int2bcd(m_cnt[k]), units_bcd};
          m_hold[k] = 1;
        end
      end else if (snap_ready) begin
        m_hold[k] = 0;
      end
      m_ovf[k] = 0;
      m_upd[k] = 0;
      if (clr) begin
        m_cnt[k] = 0;
        m_sat[k] = 0;
      end else if (tk) begin
        if (m_cnt[k] == MAXV) begin
          if (k == 0) begin
            m_cnt[k] = 0; m_ovf[k] = 1; m_upd[k] = 1;
          end else begin
            m_ovf[k] = !m_sat[k]; m_sat[k] = 1;
          end
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
          m_upd[k] = 1;
        end
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model bcd_out sat=%0d", k), 32'(bcd_o[k]), 32'(int2bcd(m_cnt[k])));
      check($sformatf("model ovf sat=%0d", k), 32'(ovf_o[k]), 32'(m_ovf[k]));
      check($sformatf("model cmp_hit sat=%0d", k), 32'(hit_o[k]), 32'(m_hit[k]));
      check($sformatf("model snap_valid sat=%0d", k), 32'(sv_o[k]), 32'(m_hold[k]));
      check($sformatf("model snap_data sat=%0d", k), 32'(snap_o[k]), 32'(m_snap[k]));
    end
  endtask

  // Advance one clock: update the model at the edge, compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      ovf_cnt[k] += int'(ovf_o[k]);
      hit_cnt[k] += int'(hit_o[k]);
    end
    check_model();
  endtask

  task automatic idle_inputs();
    tick_in = 0; hold = 0; clr = 0; snap_req = 0; snap_ready = 0; units_bcd = 4'd0;
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s bcd_out sat=%0d", tag, k), 32'(bcd_o[k]), 32'h0);
      check($sformatf("%s ovf sat=%0d", tag, k), 32'(ovf_o[k]), 32'h0);
      check($sformatf("%s cmp_hit sat=%0d", tag, k), 32'(hit_o[k]), 32'h0);
      check($sformatf("%s snap_valid sat=%0d", tag, k), 32'(sv_o[k]), 32'h0);
      check($sformatf("%s snap_data sat=%0d", tag, k), 32'(snap_o[k]), 32'h0);
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    model_reset();
    rstn = 1'b1;
  endtask

  task automatic run_ticks(input int n);
    tick_in = 1;
    repeat (n) cycle();
    tick_in = 0;
  endtask

  typedef struct {
    logic          tick, hld, cl, req, rdy;
    logic [3:0]    units;
    logic [CW-1:0] cmp;
    logic [CW-1:0] e_bcd;
    logic          e_ovf, e_hit, e_sv;
    logic [15:0]   e_snap;
  } vec_t;

  function automatic vec_t mk(input logic t, h, c, rq, rd, input logic [3:0] u,
                              input logic [CW-1:0] cv, input logic [CW-1:0] eb,
                              input logic eo, eh, es, input logic [15:0] esd);
    vec_t v;
    v.tick = t; v.hld = h; v.cl = c; v.req = rq; v.rdy = rd; v.units = u; v.cmp = cv;
    v.e_bcd = eb; v.e_ovf = eo; v.e_hit = eh; v.e_sv = es; v.e_snap = esd;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    for (int k = 0; k < 2; k++) begin ovf_cnt[k] = 0; hit_cnt[k] = 0; end
    cmp_val = 12'hFFF;
    model_reset();

    //        tick hold clr req rdy units cmp      bcd     ovf hit sv snap
    tbl[0]  = mk(1, 0, 0, 0, 0, 4'd0, 12'h002, 12'h001, 0, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 0, 0, 0, 0, 4'd0, 12'h002, 12'h002, 0, 0, 0, 16'h0000);
    tbl[2]  = mk(0, 0, 0, 0, 0, 4'd0, 12'h002, 12'h002, 0, 1, 0, 16'h0000);
    tbl[3]  = mk(1, 1, 0, 0, 0, 4'd0, 12'h002, 12'h002, 0, 0, 0, 16'h0000);
    tbl[4]  = mk(1, 0, 0, 1, 0, 4'd7, 12'h002, 12'h003, 0, 0, 1, 16'h0027);
    tbl[5]  = mk(0, 0, 0, 0, 0, 4'd1, 12'h002, 12'h003, 0, 0, 1, 16'h0027);
    tbl[6]  = mk(0, 0, 0, 1, 1, 4'd2, 12'h002, 12'h003, 0, 0, 0, 16'h0027);
    tbl[7]  = mk(1, 0, 1, 0, 0, 4'd0, 12'h002, 12'h000, 0, 0, 0, 16'h0027);
    tbl[8]  = mk(1, 0, 0, 0, 1, 4'd0, 12'h002, 12'h001, 0, 0, 0, 16'h0027);
    tbl[9]  = mk(0, 0, 0, 0, 0, 4'd0, 12'h001, 12'h001, 0, 1, 0, 16'h0027);
    tbl[10] = mk(0, 0, 0, 0, 0, 4'd0, 12'h001, 12'h001, 0, 0, 0, 16'h0027);

    // directed vector table
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      tick_in = tbl[i].tick; hold = tbl[i].hld; clr = tbl[i].cl;
      snap_req = tbl[i].req; snap_ready = tbl[i].rdy;
      units_bcd = tbl[i].units; cmp_val = tbl[i].cmp;
      cycle();
      for (int k = 0; k < 2; k++) begin
        check($sformatf("vec%0d bcd_out sat=%0d", i, k), 32'(bcd_o[k]), 32'(tbl[i].e_bcd));
        check($sformatf("vec%0d ovf sat=%0d", i, k), 32'(ovf_o[k]), 32'(tbl[i].e_ovf));
        check($sformatf("vec%0d cmp_hit sat=%0d", i, k), 32'(hit_o[k]), 32'(tbl[i].e_hit));
        check($sformatf("vec%0d snap_valid sat=%0d", i, k), 32'(sv_o[k]), 32'(tbl[i].e_sv));
        check($sformatf("vec%0d snap_data sat=%0d", i, k), 32'(snap_o[k]), 32'(tbl[i].e_snap));
      end
    end

    // full sweep, wrap vs saturate, wrap onto cmp_val=0
    apply_reset();
    cmp_val = 12'h000;
    for (int k = 0; k < 2; k++) begin ovf_cnt[k] = 0; hit_cnt[k] = 0; end
    tick_in = 1;
    for (int i = 1; i <= 999; i++) begin
      cycle();
      check("sweep step", 32'(bcd_o[0]), 32'(int2bcd(i)));
    end
    cycle();
    check("wrap bcd_out sat0", 32'(bcd_o[0]), 32'h000);
    check("wrap ovf sat0", 32'(ovf_o[0]), 32'h1);
    check("sat bcd_out sat1", 32'(bcd_o[1]), 32'h999);
    check("sat ovf sat1", 32'(ovf_o[1]), 32'h1);
    cycle();
    check("wrap ovf drop sat0", 32'(ovf_o[0]), 32'h0);
    check("wrap cmp_hit sat0", 32'(hit_o[0]), 32'h1);
    check("sat no cmp_hit sat1", 32'(hit_o[1]), 32'h0);
    repeat (4) cycle();
    tick_in = 0;
    check("sat hold bcd_out sat1", 32'(bcd_o[1]), 32'h999);
    check("ovf pulses sat0", 32'(ovf_cnt[0]), 32'd1);
    check("ovf pulses sat1", 32'(ovf_cnt[1]), 32'd1);
    check("cmp pulses sat0", 32'(hit_cnt[0]), 32'd1);
    check("cmp pulses sat1", 32'(hit_cnt[1]), 32'd0);
    clr = 1; cycle(); clr = 0;
    check("clr after sat sat1", 32'(bcd_o[1]), 32'h000);
    run_ticks(1);
    check("tick after clr sat1", 32'(bcd_o[1]), 32'h001);

    // clr and tick in the same cycle
    apply_reset();
    cmp_val = 12'hFFF;
    run_ticks(123);
    check("count 123", 32'(bcd_o[0]), 32'h123);
    cmp_val = 12'h000;
    clr = 1; tick_in = 1; cycle(); clr = 0; tick_in = 0;
    check("clr+tick bcd_out", 32'(bcd_o[0]), 32'h000);
    check("clr+tick ovf", 32'(ovf_o[0]), 32'h0);
    check("clr+tick cmp_hit", 32'(hit_o[0]), 32'h0);
    cycle();
    check("clr no later cmp_hit", 32'(hit_o[0]), 32'h0);

    // compare pulse, hold, illegal compare value
    apply_reset();
    cmp_val = 12'h042;
    for (int k = 0; k < 2; k++) hit_cnt[k] = 0;
    run_ticks(42);
    check("reach 042", 32'(bcd_o[0]), 32'h042);
    check("hit not yet", 32'(hit_o[0]), 32'h0);
    tick_in = 1; hold = 1; cycle();
    check("hold keeps 042", 32'(bcd_o[0]), 32'h042);
    check("hit one after", 32'(hit_o[0]), 32'h1);
    cycle();
    tick_in = 0; hold = 0;
    check("no second hit", 32'(hit_o[0]), 32'h0);
    check("one hit total", 32'(hit_cnt[0]), 32'd1);
    cmp_val = 12'h0A0;
    for (int k = 0; k < 2; k++) hit_cnt[k] = 0;
    run_ticks(200);
    check("0A0 never hits", 32'(hit_cnt[0]), 32'd0);

    // snapshot hold with ticks running
    apply_reset();
    cmp_val = 12'hFFF;
    run_ticks(317);
    units_bcd = 4'd5; snap_req = 1; cycle(); snap_req = 0;
    tick_in = 1;
    for (int i = 0; i < 10; i++) begin
      snap_req = (i == 4);
      units_bcd = 4'(i % 10);
      check($sformatf("snap valid %0d", i), 32'(sv_o[0]), 32'h1);
      check($sformatf("snap data %0d", i), 32'(snap_o[0]), 32'h3175);
      cycle();
    end
    snap_req = 0;
    check("snap data after ignored req", 32'(snap_o[0]), 32'h3175);
    snap_ready = 1; cycle(); snap_ready = 0; tick_in = 0;
    check("snap valid drops", 32'(sv_o[0]), 32'h0);

    // asynchronous reset mid-handshake
    apply_reset();
    run_ticks(250);
    snap_req = 1; cycle(); snap_req = 0;
    check("pre-reset count", 32'(bcd_o[0]), 32'h250);
    check("pre-reset valid", 32'(sv_o[0]), 32'h1);
    #2 rstn = 1'b0;
    #1 check_zero("async reset");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    run_ticks(1);
    check("first tick after reset", 32'(bcd_o[0]), 32'h001);

    // randomized stimulus against the model
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      tick_in    = ($urandom_range(0, 9) != 0);
      hold       = ($urandom_range(0, 9) == 0);
      clr        = ($urandom_range(0, 1999) == 0);
      snap_req   = ($urandom_range(0, 4) == 0);
      snap_ready = ($urandom_range(0, 2) == 0);
      units_bcd  = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: cmp_val = int2bcd($urandom_range(0, 60));
          1: cmp_val = int2bcd($urandom_range(0, 999));
          2: cmp_val = 12'($urandom);
          default: cmp_val = 12'h999;
        endcase
      end
      cycle();
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
